// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:16 stream demultiplexer.
package demux_pkg;

  localparam int NUM_CH  = 16;
  localparam int SEL_W   = 4;
  localparam int GRP_W   = 2;
  localparam int NUM_GRP = NUM_CH / 4;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

  // Low bit of channel ch inside a flattened NUM_CH*width bus.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/demux1to4.sv
// Combinational 1:4 one-hot decoder with enable; zero latency, no flow control.
module demux1to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux16_stream.sv
// Routes a valid/ready stream into 16 single-word channel registers; 1 cycle latency.
// in_ready drops only when the selected channel is full and not draining this cycle.
module demux16_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data
);

  logic                accept;
  logic [NUM_GRP-1:0]  grp_en;
  ch_mask_t            load;
  ch_mask_t            full;

  // A full channel still accepts when it drains in the same cycle, so streaming has no bubble.
  assign in_ready = ~full[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  demux1to4 u_lvl1 (
    .en     (accept),
    .sel    (in_sel[SEL_W-1:GRP_W]),
    .onehot (grp_en)
  );

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_lvl2
    demux1to4 u_lvl2 (
      .en     (grp_en[g]),
      .sel    (in_sel[GRP_W-1:0]),
      .onehot (load[g*4 +: 4])
    );
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic             full_q;
    logic [WIDTH-1:0] data_q;

    // Load wins over drain: a simultaneous drain and reload keeps the channel full.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else if (load[k]) begin
        full_q <= 1'b1;
        data_q <= in_data;
      end else if (full_q && out_ready[k]) begin
        full_q <= 1'b0;
      end
    end

    assign full[k] = full_q;
    assign out_data[ch_lsb(k, WIDTH) +: WIDTH] = data_q;
  end

  assign out_valid = full;

endmodule

// File: doc/demux16_stream.md
DEMUX16_STREAM -- requirements
Module: demux16_stream

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits of every channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is asynchronous and active-high.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  block accepts the upstream word this cycle.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 in_sel  input  4  destination channel index 0..15, sampled with in_data.
REQ-008 out_valid  output  16  bit k high: channel k holds a word.
REQ-009 out_ready  input  16  bit k high: channel k consumer takes its word.
REQ-010 out_data  output  16*WIDTH  channel k word on bits [k*WIDTH +: WIDTH].

Function
REQ-011 Each channel k SHALL own one WIDTH-bit holding register and a full flag; out_valid[k] equals that full flag.
REQ-012 Channel k drains when out_valid[k] and out_ready[k] are both high at a clock edge; it then clears full[k] unless it is reloaded in the same cycle.
REQ-013 in_ready SHALL equal !full[in_sel] | out_ready[in_sel], so the channel can be reloaded in the cycle it drains; in_ready depends only on in_sel, full and out_ready, never on in_valid.
REQ-014 Accept occurs when in_valid and in_ready are both high; on accept, register[in_sel] loads in_data and full[in_sel] sets at that edge.
REQ-015 Latency: a word accepted at edge N appears on out_data and out_valid of its channel after edge N; there is one cycle of latency and no combinational path from in_data to out_data.
REQ-016 Only the selected channel is affected by an accept; the other 15 registers and flags hold unless they are draining.
REQ-017 Simultaneous drain and reload of the same channel SHALL leave full=1 with the new word, with no bubble.
REQ-018 When the selected channel is full and its out_ready is low, in_ready=0; the upstream word, its select and its valid must be held by the sender, and no data is lost or duplicated.
REQ-019 Drains on any channel proceed independently of in_valid and in_sel; up to 16 channels may drain in one cycle.
REQ-020 out_data[k] SHALL hold its value while out_valid[k]=1 and out_ready[k]=0.
REQ-021 Channel load enables SHALL be produced by a one-hot 1:16 decode of in_sel gated by accept.

Reset
REQ-022 When rst asserts, all full flags clear immediately: out_valid=16'h0000, in_ready=1 for any in_sel.
REQ-023 Holding registers reset to all-zero, so out_data=0.
REQ-024 A transfer in flight when reset asserts is discarded; the first accept after rst deasserts behaves as in REQ-014.

Structure
REQ-025 Shared package demux_pkg SHALL hold NUM_CH=16, SEL_W=4 and a function or constant for the channel index range.
REQ-026 Sub-module demux1to4 (combinational: 1-bit enable, 2-bit select, 4-bit one-hot output) SHALL be instantiated five times as a two-level tree.
REQ-027 The first level of the tree decodes in_sel[3:2]; the second level decodes in_sel[1:0].
REQ-028 The per-channel registers SHALL be a generate loop in demux16_stream.

Verification
REQ-029 Reset then idle: out_valid=0, out_data=0, and in_ready=1 for every in_sel value 0..15.
REQ-030 Single route: in_sel=4'hA, in_data=8'h5C, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=16'h0400 and channel 10 data=8'h5C, all others 0.
REQ-031 Backpressure: channel 3 full and out_ready[3]=0, send to in_sel=3 -> in_ready=0 and the sender holds; raise out_ready[3] -> the same cycle in_ready=1, and the next cycle channel 3 holds the new word with out_valid[3] still 1.
REQ-032 Independent channels: fill channels 0, 7 and 15 with 8'h11, 8'h77 and 8'hFF, then pulse out_ready=16'h8081 -> all three drain in one cycle and out_valid returns to 0.
REQ-033 Streaming: 16 back-to-back words with in_sel=0..15 and out_ready all 1 -> in_ready stays high throughout, and each channel shows its word exactly once, one cycle after it was accepted.
REQ-034 Mid-operation reset: with channels 2 and 9 full, assert rst asynchronously between edges -> out_valid goes to 0 before the next edge and no stale word reappears after deassert.
